aes_dec_ctrl: RTL
=================

# aes_dec_ctrl

Iterative AES-128 decryption controller. It accepts one 128-bit ciphertext block over a valid/ready handshake and sequences the initial AddRoundKey, nine full inverse rounds and the final inverse round through a single shared inverse-round datapath, one round per clock. It fetches round keys from the external key-schedule store by index and returns the plaintext over a second valid/ready handshake. It sits between the decryption front-end and the key-schedule block.

## Interface
- NR, 10, number of AES rounds; fixed for AES-128.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ciphertext present on in_data.
- in_ready  out  1  block can accept ciphertext.
- in_data  in  128  ciphertext; byte 0 (FIPS-197 order, column-major) in [127:120].
- out_valid  out  1  plaintext present on out_data.
- out_ready  in  1  consumer accepts plaintext.
- out_data  out  128  plaintext, same byte order as in_data.
- rk_idx  out  4  round-key index requested, 0..10.
- rk_data  in  128  round key for rk_idx; combinational, valid in the same cycle.
- busy  out  1  high in ROUND and FINAL.

## Operation
- States: IDLE, ROUND, FINAL, DONE; 4-bit round counter `rnd`; 128-bit state register `st`.
- IDLE:
  - in_ready=1, rk_idx=10.
  - On in_valid: st <= in_data ^ rk_data, rnd <= 9, go ROUND.
- ROUND:
  - rk_idx=rnd.
  - st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk_data).
  - If rnd==1, go FINAL; otherwise rnd <= rnd-1.
- FINAL:
  - rk_idx=0.
  - st <= InvSubBytes(InvShiftRows(st)) ^ rk_data.
  - Go DONE.
- DONE:
  - out_valid=1, out_data=st, rk_idx=0.
  - On out_ready: go IDLE.
- in_ready is high only in IDLE. No new block is accepted while a block is in flight or waiting in DONE.
- In DONE, out_data and out_valid hold stable until out_ready is sampled high; back-pressure may last indefinitely.
- in_valid outside IDLE is ignored. in_data is sampled only on the accepting edge.
- In ROUND, the InvMixColumns input is the full 128-bit AddRoundKey result. Each 32-bit column is an independent GF(2^8) matrix product using rows {0e,0b,0d,09} rotated. Multiplication is true xtime-based GF multiplication, not bitwise AND.
- Illegal state encodings return to IDLE on the next edge.

## Timing
- Reset (any time, including mid-block):
  - state=IDLE, rnd=0, st=0.
  - in_ready=1, out_valid=0, busy=0, rk_idx=10, out_data=0.
  - The in-flight block is discarded and no partial output appears.
- Latency:
  - Accept edge E0 → ROUND at edges E1..E9 → FINAL at E10 → out_valid high in the cycle after E10.
  - This gives 10 cycles from the accept edge to out_valid.
- If out_ready is high in the first DONE cycle, in_ready rises in the next cycle. Minimum issue interval is 12 cycles.
- rk_idx is a registered-state decode, stable for the whole cycle. The key store must return rk_data combinationally in the same cycle.
- Per accepted block, rk_idx visits the sequence 10, 9, 8, …, 1, 0 exactly once.

## Structure
- Shared package `aes_pkg`:
  - NR
  - state enum {IDLE, ROUND, FINAL, DONE}
  - 128-bit block typedef
  - GF(2^8) xtime/mul functions
  - inverse S-box table
- Sub-module `aes_inv_round`, purely combinational:
  - Inputs: st, rk, last. Output: next state.
  - Computes InvShiftRows → InvSubBytes → AddRoundKey, then InvMixColumns unless last=1.
  - FINAL drives last=1; ROUND drives last=0.
- The controller holds only the FSM, the counter, the st register and the handshake logic.

## Test plan
- FIPS-197 C.1: key 000102…0f schedule, ct 69c4e0d86a7b0430d8cdb78070b4c55a → out_data 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after the accept edge.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → pt 3243f6a8885a308d313198a2e0370734. rk_idx log reads 10, 9, …, 0.
- Back-pressure: out_ready held low 20 cycles → out_data/out_valid stable; in_valid pulses during the wait are ignored (in_ready=0); release → IDLE next cycle.
- Back-to-back: in_valid and out_ready held high, two C.1 blocks → both decrypt correctly, second accept 12 cycles after the first.
- Reset mid-block: assert rst_n low at the ROUND cycle with rnd=5 → all outputs at reset values immediately (asynchronous); after release, a fresh C.1 block decrypts correctly.
- InvMixColumns column check: force st so the AddRoundKey output column is 8e4da1bc → ROUND output column is db135345.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 decryption definitions: round count, FSM state, block type,
// GF(2^8) arithmetic and the inverse S-box.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // Entry for byte value v sits at bits [2047-8v -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] nxt
);

    block_t ark;
    block_t mixed;

    // Byte k is row k%4, column k/4; row r is rotated right by r columns.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = ((COL - ROW + 4) % 4) * 4 + ROW;
        assign ark[127 - 8 * gi -: 8] = inv_sbox(st[127 - 8 * SRC -: 8]) ^ rk[127 - 8 * gi -: 8];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark[127 - 32 * gi -: 8];
        assign a1 = ark[119 - 32 * gi -: 8];
        assign a2 = ark[111 - 32 * gi -: 8];
        assign a3 = ark[103 - 32 * gi -: 8];
        assign mixed[127 - 32 * gi -: 32] = {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
        };
    end

    assign nxt = last ? ark : mixed;

endmodule

// File: rtl/aes_dec_ctrl.sv
// Iterative AES-128 decryption controller: one inverse round per clock through
// a shared datapath, with round keys fetched from an external store by index.
module aes_dec_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         busy
);

    state_t     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    block_t     st_q, st_d;
    block_t     round_out;
    logic       last_round;

    assign last_round = (state_q == FINAL);

    aes_inv_round u_inv_round (
        .st   (st_q),
        .rk   (rk_data),
        .last (last_round),
        .nxt  (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        st_d      = st_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        rk_idx    = 4'(NR);
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = in_data ^ rk_data;
                    rnd_d   = 4'(NR - 1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                busy   = 1'b1;
                rk_idx = rnd_q;
                st_d   = round_out;
                if (rnd_q == 4'd1) state_d = FINAL;
                else               rnd_d   = rnd_q - 4'd1;
            end
            FINAL: begin
                busy    = 1'b1;
                rk_idx  = 4'd0;
                st_d    = round_out;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = st_q;
                rk_idx    = 4'd0;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
